// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the RV32 memory-access stage:
//   - CFG_XLEN / CFG_REG_AW : default data/address and register-index widths
//   - F3_* constants        : load/store funct3 encodings
//   - mem_state_e           : request/response sequencing states
//   - is_misaligned()       : alignment check used by the optional trap
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int CFG_XLEN   = 32;
  localparam int CFG_REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Halfword accesses need an even address, word accesses a zero offset.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// -----------------------------------------------------------------------------
// mem_lsu_align
// Purely combinational byte-lane logic for a 32-bit data port.
//   funct3       in  3   access size / signedness
//   byte_off     in  2   address bits [1:0]
//   st_data      in  32  store data (rs2)
//   ld_word      in  32  word returned by memory
//   st_strb      out 4   byte strobes (shifted past lane 3 are dropped)
//   st_lane_data out 32  store data replicated into every lane
//   ld_data      out 32  selected and sign/zero-extended load data
// -----------------------------------------------------------------------------
module mem_lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_strb,
  output logic [31:0] st_lane_data,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift_s;

  // Store strobes and lane replication; memory picks the lanes via the strobes.
  always_comb begin
    st_strb      = 4'b0000;
    st_lane_data = 32'h0000_0000;
    case (funct3)
      F3_SB: begin
        st_strb      = 4'b0001 << byte_off;
        st_lane_data = {4{st_data[7:0]}};
      end
      F3_SH: begin
        st_strb      = 4'b0011 << byte_off;
        st_lane_data = {2{st_data[15:0]}};
      end
      F3_SW: begin
        st_strb      = 4'b1111;
        st_lane_data = st_data;
      end
      default: begin
        st_strb      = 4'b0000;
        st_lane_data = 32'h0000_0000;
      end
    endcase
  end

  // Move the addressed byte/half down to bit 0, then extend.
  always_comb begin
    ld_shift_s = ld_word >> {byte_off, 3'b000};
    case (funct3)
      F3_LB:   ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
      F3_LBU:  ld_data = {24'h00_0000, ld_shift_s[7:0]};
      F3_LH:   ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
      F3_LHU:  ld_data = {16'h0000, ld_shift_s[15:0]};
      F3_LW:   ld_data = ld_shift_s;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage between EX and WB of the 5-stage RV32 core. Takes one
// instruction per handshake, issues load/store requests to the data-memory
// port, extends load data and registers the result into the MEM->WB pipe.
// Non-memory instructions and zero-wait stores pass in one cycle.
//
// Ports:
//   clk, rst_b (synchronous, active-high)
//   EX->MEM : mem_pipe_valid/ready/flush, pc, instruction, rd_write, rd_addr,
//             alu_result (address for memory ops), mem_read, mem_write,
//             mem_funct3, mem_wdata
//   DMEM    : dmem_req_valid/ready/write/addr/wstrb/wdata,
//             dmem_rsp_valid/rdata
//   MEM->WB : wb_pipe_valid/ready/flush, pc, instruction, rd_write, rd_addr,
//             rd_data, and wb_pipe_misalign when the trap is built in
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned LH/LHU/SH and
// LW/SW instead of issuing them with truncated strobes.
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = mem_stage_pkg::CFG_XLEN,
  parameter int REG_AW = mem_stage_pkg::CFG_REG_AW
) (
  input  logic              clk,
  input  logic              rst_b,
  output logic              mem_pipe_ready,
  output logic              mem_pipe_flush,
  input  logic              mem_pipe_valid,
  input  logic [XLEN-1:0]   mem_pipe_pc,
  input  logic [XLEN-1:0]   mem_pipe_instruction,
  input  logic              mem_pipe_rd_write,
  input  logic [REG_AW-1:0] mem_pipe_rd_addr,
  input  logic [XLEN-1:0]   mem_pipe_alu_result,
  input  logic              mem_pipe_mem_read,
  input  logic              mem_pipe_mem_write,
  input  logic [2:0]        mem_pipe_mem_funct3,
  input  logic [XLEN-1:0]   mem_pipe_mem_wdata,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_write,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic [3:0]        dmem_req_wstrb,
  output logic [XLEN-1:0]   dmem_req_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rsp_rdata,
  input  logic              wb_pipe_ready,
  input  logic              wb_pipe_flush,
  output logic              wb_pipe_valid,
  output logic [XLEN-1:0]   wb_pipe_pc,
  output logic [XLEN-1:0]   wb_pipe_instruction,
  output logic              wb_pipe_rd_write,
  output logic [REG_AW-1:0] wb_pipe_rd_addr,
  output logic [XLEN-1:0]   wb_pipe_rd_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              wb_pipe_misalign
`endif
);

  // WB never flushes this stage; the input exists only for interface symmetry.
  logic unused_wb_flush_s;
  assign unused_wb_flush_s = wb_pipe_flush;

  mem_state_e state_q, state_d;

  // Request fields held stable while the memory port stalls (REQ) and the
  // access shape needed to extend the response (RESP).
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            req_write_q, req_write_d;
  logic [3:0]      req_wstrb_q, req_wstrb_d;
  logic [XLEN-1:0] req_wdata_q, req_wdata_d;
  logic [2:0]      req_funct3_q, req_funct3_d;
  logic [1:0]      req_off_q, req_off_d;

  // Memory side finished while WB was full: remember it so the access is
  // neither repeated nor lost; load data parks in ld_hold.
  logic            done_q, done_d;
  logic [XLEN-1:0] ld_hold_q, ld_hold_d;

  logic              wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]   wb_pc_q, wb_pc_d;
  logic [XLEN-1:0]   wb_instr_q, wb_instr_d;
  logic              wb_rd_write_q, wb_rd_write_d;
  logic [REG_AW-1:0] wb_rd_addr_q, wb_rd_addr_d;
  logic [XLEN-1:0]   wb_rd_data_q, wb_rd_data_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              wb_misalign_q, wb_misalign_d;
`endif

  logic            is_mem_s;
  logic            trap_s;
  logic            slot_free_s;
  logic            mem_done_s;
  logic            req_valid_s;
  logic            accept_s;
  logic [XLEN-1:0] mem_rdata_s;
  logic [2:0]      al_funct3_s;
  logic [1:0]      al_off_s;
  logic [3:0]      al_wstrb_s;
  logic [XLEN-1:0] al_wdata_s;
  logic [XLEN-1:0] al_ld_data_s;
  logic [3:0]      cur_wstrb_s;

  assign is_mem_s    = mem_pipe_mem_read | mem_pipe_mem_write;
  assign slot_free_s = wb_pipe_ready | ~wb_valid_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_s = is_mem_s & is_misaligned(mem_pipe_mem_funct3, mem_pipe_alu_result[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  // Lane logic sees the live instruction in IDLE and the latched shape afterwards.
  always_comb begin
    if (state_q == IDLE) begin
      al_funct3_s = mem_pipe_mem_funct3;
      al_off_s    = mem_pipe_alu_result[1:0];
    end else begin
      al_funct3_s = req_funct3_q;
      al_off_s    = req_off_q;
    end
  end

  mem_lsu_align u_align (
    .funct3       (al_funct3_s),
    .byte_off     (al_off_s),
    .st_data      (mem_pipe_mem_wdata),
    .ld_word      (dmem_rsp_rdata),
    .st_strb      (al_wstrb_s),
    .st_lane_data (al_wdata_s),
    .ld_data      (al_ld_data_s)
  );

  // Loads carry no strobes.
  always_comb begin
    if (mem_pipe_mem_read) begin
      cur_wstrb_s = 4'b0000;
    end else begin
      cur_wstrb_s = al_wstrb_s;
    end
  end

  // Request/response sequencing and the memory-complete indication.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_write_d  = req_write_q;
    req_wstrb_d  = req_wstrb_q;
    req_wdata_d  = req_wdata_q;
    req_funct3_d = req_funct3_q;
    req_off_d    = req_off_q;
    done_d       = done_q;
    ld_hold_d    = ld_hold_q;
    mem_done_s   = 1'b0;
    req_valid_s  = 1'b0;
    mem_rdata_s  = ld_hold_q;
    case (state_q)
      IDLE: begin
        if (done_q) begin
          mem_done_s = 1'b1;
          done_d     = ~slot_free_s;
        end else if (!(mem_pipe_valid && is_mem_s) || trap_s) begin
          mem_done_s = 1'b1;
        end else begin
          req_valid_s  = 1'b1;
          req_addr_d   = {mem_pipe_alu_result[XLEN-1:2], 2'b00};
          req_write_d  = ~mem_pipe_mem_read;
          req_wstrb_d  = cur_wstrb_s;
          req_wdata_d  = al_wdata_s;
          req_funct3_d = mem_pipe_mem_funct3;
          req_off_d    = mem_pipe_alu_result[1:0];
          if (!dmem_req_ready) begin
            state_d = REQ;
          end else if (mem_pipe_mem_read) begin
            state_d = RESP;
          end else begin
            mem_done_s = 1'b1;
            done_d     = ~slot_free_s;
          end
        end
      end
      REQ: begin
        req_valid_s = 1'b1;
        if (!dmem_req_ready) begin
          state_d = REQ;
        end else if (req_write_q) begin
          mem_done_s = 1'b1;
          done_d     = ~slot_free_s;
          state_d    = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (dmem_rsp_valid) begin
          mem_done_s  = 1'b1;
          mem_rdata_s = al_ld_data_s;
          ld_hold_d   = al_ld_data_s;
          done_d      = ~slot_free_s;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_pipe_ready = mem_done_s & slot_free_s;
  assign accept_s       = mem_pipe_valid & mem_pipe_ready;

  // Memory request port: live fields in IDLE, latched fields while stalled.
  always_comb begin
    dmem_req_valid = req_valid_s & ~rst_b;
    if (state_q == REQ) begin
      dmem_req_write = req_write_q;
      dmem_req_addr  = req_addr_q;
      dmem_req_wstrb = req_wstrb_q;
      dmem_req_wdata = req_wdata_q;
    end else begin
      dmem_req_write = ~mem_pipe_mem_read & mem_pipe_mem_write;
      dmem_req_addr  = {mem_pipe_alu_result[XLEN-1:2], 2'b00};
      dmem_req_wstrb = cur_wstrb_s;
      dmem_req_wdata = al_wdata_s;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign mem_pipe_flush = accept_s & trap_s & ~rst_b;
`else
  assign mem_pipe_flush = 1'b0;
`endif

  // MEM->WB register: load on accept, drain when WB takes it, else hold.
  always_comb begin
    wb_valid_d    = wb_valid_q;
    wb_pc_d       = wb_pc_q;
    wb_instr_d    = wb_instr_q;
    wb_rd_write_d = wb_rd_write_q;
    wb_rd_addr_d  = wb_rd_addr_q;
    wb_rd_data_d  = wb_rd_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    wb_misalign_d = wb_misalign_q;
`endif
    if (accept_s) begin
      wb_valid_d    = 1'b1;
      wb_pc_d       = mem_pipe_pc;
      wb_instr_d    = mem_pipe_instruction;
      wb_rd_write_d = mem_pipe_rd_write & ~trap_s;
      wb_rd_addr_d  = mem_pipe_rd_addr;
      if (mem_pipe_mem_read && !trap_s) begin
        wb_rd_data_d = mem_rdata_s;
      end else begin
        wb_rd_data_d = mem_pipe_alu_result;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misalign_d = trap_s;
`endif
    end else if (wb_pipe_ready) begin
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d = wb_valid_q;
    end
  end

  // State, request latches and MEM->WB register.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      req_write_q   <= 1'b0;
      req_wstrb_q   <= 4'b0000;
      req_wdata_q   <= '0;
      req_funct3_q  <= 3'b000;
      req_off_q     <= 2'b00;
      done_q        <= 1'b0;
      ld_hold_q     <= '0;
      wb_valid_q    <= 1'b0;
      wb_pc_q       <= '0;
      wb_instr_q    <= '0;
      wb_rd_write_q <= 1'b0;
      wb_rd_addr_q  <= '0;
      wb_rd_data_q  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misalign_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      req_write_q   <= req_write_d;
      req_wstrb_q   <= req_wstrb_d;
      req_wdata_q   <= req_wdata_d;
      req_funct3_q  <= req_funct3_d;
      req_off_q     <= req_off_d;
      done_q        <= done_d;
      ld_hold_q     <= ld_hold_d;
      wb_valid_q    <= wb_valid_d;
      wb_pc_q       <= wb_pc_d;
      wb_instr_q    <= wb_instr_d;
      wb_rd_write_q <= wb_rd_write_d;
      wb_rd_addr_q  <= wb_rd_addr_d;
      wb_rd_data_q  <= wb_rd_data_d;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misalign_q <= wb_misalign_d;
`endif
    end
  end

  assign wb_pipe_valid       = wb_valid_q;
  assign wb_pipe_pc          = wb_pc_q;
  assign wb_pipe_instruction = wb_instr_q;
  assign wb_pipe_rd_write    = wb_rd_write_q;
  assign wb_pipe_rd_addr     = wb_rd_addr_q;
  assign wb_pipe_rd_data     = wb_rd_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign wb_pipe_misalign    = wb_misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Table-driven bench for mem_stage: each record carries an instruction, the
// memory behaviour to emulate (request wait states, response delay, load word)
// and the expected request fields, writeback data and accept latency.
// Writeback expectations go into a queue on accept and are compared when the
// stage hands the result to WB. Hand-written sequences cover WB back-pressure,
// reset while waiting for a response, and the optional misalign trap.
// -----------------------------------------------------------------------------
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        mem_pipe_ready, mem_pipe_flush, mem_pipe_valid;
  logic [31:0] mem_pipe_pc, mem_pipe_instruction, mem_pipe_alu_result, mem_pipe_mem_wdata;
  logic        mem_pipe_rd_write, mem_pipe_mem_read, mem_pipe_mem_write;
  logic [4:0]  mem_pipe_rd_addr;
  logic [2:0]  mem_pipe_mem_funct3;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_write;
  logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_rsp_valid;
  logic        wb_pipe_ready, wb_pipe_flush, wb_pipe_valid, wb_pipe_rd_write;
  logic [31:0] wb_pipe_pc, wb_pipe_instruction, wb_pipe_rd_data;
  logic [4:0]  wb_pipe_rd_addr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        wb_pipe_misalign;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_b(rst_b),
    .mem_pipe_ready(mem_pipe_ready), .mem_pipe_flush(mem_pipe_flush),
    .mem_pipe_valid(mem_pipe_valid), .mem_pipe_pc(mem_pipe_pc),
    .mem_pipe_instruction(mem_pipe_instruction), .mem_pipe_rd_write(mem_pipe_rd_write),
    .mem_pipe_rd_addr(mem_pipe_rd_addr), .mem_pipe_alu_result(mem_pipe_alu_result),
    .mem_pipe_mem_read(mem_pipe_mem_read), .mem_pipe_mem_write(mem_pipe_mem_write),
    .mem_pipe_mem_funct3(mem_pipe_mem_funct3), .mem_pipe_mem_wdata(mem_pipe_mem_wdata),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_write(dmem_req_write), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .wb_pipe_ready(wb_pipe_ready), .wb_pipe_flush(wb_pipe_flush),
    .wb_pipe_valid(wb_pipe_valid), .wb_pipe_pc(wb_pipe_pc),
    .wb_pipe_instruction(wb_pipe_instruction), .wb_pipe_rd_write(wb_pipe_rd_write),
    .wb_pipe_rd_addr(wb_pipe_rd_addr), .wb_pipe_rd_data(wb_pipe_rd_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .wb_pipe_misalign(wb_pipe_misalign)
`endif
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  rd_addr;
    logic        rd_write;
    int          wait_cyc, rsp_dly;
    logic [31:0] exp_rd_data;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr, rd_data;
    logic        rd_write;
    logic [4:0]  rd_addr;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic [4:0] rd_addr,
                              input logic rd_write, input int wait_cyc, input int rsp_dly,
                              input logic [31:0] exp_rd_data, input logic [3:0] exp_wstrb,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.rd_addr = rd_addr; v.rd_write = rd_write; v.wait_cyc = wait_cyc; v.rsp_dly = rsp_dly;
    v.exp_rd_data = exp_rd_data; v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic clear_inputs();
    mem_pipe_valid = 1'b0; mem_pipe_mem_read = 1'b0; mem_pipe_mem_write = 1'b0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic run_vec(input vec_t v, input int idx);
    bit   seen, fired, accepted, fire_now, is_mem;
    int   waits, rsp_cnt, exp_lat;
    exp_t e;
    string tag;
    tag = $sformatf("v%0d", idx);
    is_mem = v.rd | v.wr;
    mem_pipe_valid = 1'b1;
    mem_pipe_pc = 32'h1000 + 32'(idx) * 32'd4;
    mem_pipe_instruction = (32'(idx) << 12) | 32'h0000_0003;
    mem_pipe_rd_write = v.rd_write; mem_pipe_rd_addr = v.rd_addr;
    mem_pipe_alu_result = v.addr; mem_pipe_mem_read = v.rd; mem_pipe_mem_write = v.wr;
    mem_pipe_mem_funct3 = v.f3; mem_pipe_mem_wdata = v.wdata;
    dmem_req_ready = (v.wait_cyc == 0); dmem_rsp_valid = 1'b0; dmem_rsp_rdata = v.rdata;
    exp_lat = !is_mem ? 0 : (v.wr ? v.wait_cyc : v.wait_cyc + 1 + v.rsp_dly);
    seen = 0; fired = 0; accepted = 0; waits = 0; rsp_cnt = 0;
    for (int cyc = 0; cyc < 40 && !accepted; cyc++) begin
      @(negedge clk);
      fire_now = 0;
      if (!is_mem && cyc == 0) chk({tag, "_noreq"}, 32'(dmem_req_valid), 32'd0);
      if (dmem_req_valid) begin
        if (!seen) begin
          chk({tag, "_addr"}, dmem_req_addr, {v.addr[31:2], 2'b00});
          chk({tag, "_write"}, 32'(dmem_req_write), 32'(v.wr));
          if (v.wr) begin
            chk({tag, "_wstrb"}, 32'(dmem_req_wstrb), 32'(v.exp_wstrb));
            chk({tag, "_wdata"}, dmem_req_wdata, v.exp_wdata);
          end
          seen = 1;
        end else begin
          chk({tag, "_addr_hold"}, dmem_req_addr, {v.addr[31:2], 2'b00});
        end
        if (dmem_req_ready) fire_now = 1;
        else waits++;
      end
      if (mem_pipe_ready) begin
        accepted = 1;
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        e.pc = mem_pipe_pc; e.instr = mem_pipe_instruction; e.rd_data = v.exp_rd_data;
        e.rd_write = v.rd_write; e.rd_addr = v.rd_addr;
        sb_q.push_back(e);
      end
      @(posedge clk); #1;
      if (accepted) begin
        clear_inputs();
      end else if (fire_now) begin
        fired = 1;
        dmem_req_ready = 1'b0;
        if (v.rsp_dly == 0) dmem_rsp_valid = 1'b1;
      end else if (fired) begin
        rsp_cnt++;
        if (rsp_cnt >= v.rsp_dly) dmem_rsp_valid = 1'b1;
      end else if (seen && waits >= v.wait_cyc) begin
        dmem_req_ready = 1'b1;
      end
    end
    if (!accepted) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: got no accept expected accept within 40 cycles", tag);
      clear_inputs();
    end
  endtask

  // Scoreboard: compare each result as WB takes it.
  always @(negedge clk) begin
    if (!rst_b && wb_pipe_valid && wb_pipe_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL wb_unexpected: got output pc %h expected none", wb_pipe_pc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wb_pc", wb_pipe_pc, mon_e.pc);
        chk("wb_instr", wb_pipe_instruction, mon_e.instr);
        chk("wb_rd_data", wb_pipe_rd_data, mon_e.rd_data);
        chk("wb_rd_addr", 32'(wb_pipe_rd_addr), 32'(mon_e.rd_addr));
        chk("wb_rd_write", 32'(wb_pipe_rd_write), 32'(mon_e.rd_write));
      end
    end
  end

  initial begin
    rst_b = 1'b1; wb_pipe_ready = 1'b1; wb_pipe_flush = 1'b0;
    mem_pipe_pc = 32'h0; mem_pipe_instruction = 32'h0; mem_pipe_alu_result = 32'h0;
    mem_pipe_mem_wdata = 32'h0; mem_pipe_rd_write = 1'b0; mem_pipe_rd_addr = 5'd0;
    mem_pipe_mem_funct3 = 3'd0; dmem_rsp_rdata = 32'h0;
    clear_inputs();

    //      rd    wr    f3     addr          wdata         rdata         rd    rdw   wt dly exp_rd_data   strb     exp_wdata
    tbl.push_back(mk(1'b0, 1'b0, 3'd0,  32'h0000_1234, 32'h0,        32'h0,        5'd5,  1'b1, 0, 0, 32'h0000_1234, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, F3_LB, 32'h0000_0103, 32'h0,        32'h80FF_0000, 5'd6, 1'b1, 2, 0, 32'hFFFF_FF80, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, F3_LBU,32'h0000_0103, 32'h0,        32'h80FF_0000, 5'd7, 1'b1, 0, 0, 32'h0000_0080, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, F3_SH, 32'h0000_0022, 32'h0000_ABCD, 32'h0,       5'd0, 1'b0, 0, 0, 32'h0000_0022, 4'b1100, 32'hABCD_ABCD));
    tbl.push_back(mk(1'b0, 1'b1, F3_SB, 32'h0000_0041, 32'h1234_565A, 32'h0,       5'd0, 1'b0, 1, 0, 32'h0000_0041, 4'b0010, 32'h5A5A_5A5A));
    tbl.push_back(mk(1'b0, 1'b1, F3_SW, 32'h0000_0080, 32'hDEAD_BEEF, 32'h0,       5'd0, 1'b0, 0, 0, 32'h0000_0080, 4'b1111, 32'hDEAD_BEEF));
    tbl.push_back(mk(1'b1, 1'b0, F3_LH, 32'h0000_0202, 32'h0,        32'h8001_1234, 5'd8, 1'b1, 0, 1, 32'hFFFF_8001, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, F3_LHU,32'h0000_0200, 32'h0,        32'h8001_F234, 5'd9, 1'b1, 0, 0, 32'h0000_F234, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, F3_LW, 32'h0000_0304, 32'h0,        32'hCAFE_BABE, 5'd10, 1'b1, 1, 2, 32'hCAFE_BABE, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, F3_LB, 32'h0000_0010, 32'h0,        32'h0000_007F, 5'd11, 1'b1, 0, 0, 32'h0000_007F, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 3'd0,  32'hFFFF_FFFF, 32'h0,        32'h0,        5'd31, 1'b1, 0, 0, 32'hFFFF_FFFF, 4'b0000, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, F3_LH, 32'h0000_0002, 32'h0,        32'h7FFF_0000, 5'd12, 1'b1, 0, 0, 32'h0000_7FFF, 4'b0000, 32'h0));
`ifndef MEM_MISALIGN_TRAP_EN
    // Misaligned accesses go out as-is; the SH strobe loses its upper bit.
    tbl.push_back(mk(1'b0, 1'b1, F3_SH, 32'h0000_0023, 32'h0000_1122, 32'h0,       5'd0, 1'b0, 0, 0, 32'h0000_0023, 4'b1000, 32'h1122_1122));
    tbl.push_back(mk(1'b1, 1'b0, F3_LH, 32'h0000_0203, 32'h0,        32'h8000_0000, 5'd13, 1'b1, 0, 0, 32'h0000_0080, 4'b0000, 32'h0));
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_pipe_valid), 32'd0);
    chk("rst_wb_pc", wb_pipe_pc, 32'h0);
    chk("rst_wb_rd_data", wb_pipe_rd_data, 32'h0);
    chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst_flush", 32'(mem_pipe_flush), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);
    idle(2);

    // WB back-pressure: held output blocks the next instruction.
    wb_pipe_ready = 1'b0;
    run_vec(mk(1'b0, 1'b0, 3'd0, 32'h0000_AAAA, 32'h0, 32'h0, 5'd3, 1'b1, 0, 0,
               32'h0000_AAAA, 4'b0000, 32'h0), 20);
    mem_pipe_valid = 1'b1; mem_pipe_alu_result = 32'h0000_BBBB; mem_pipe_rd_addr = 5'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ready", 32'(mem_pipe_ready), 32'd0);
      chk("stall_valid", 32'(wb_pipe_valid), 32'd1);
      chk("stall_hold", wb_pipe_rd_data, 32'h0000_AAAA);
      @(posedge clk); #1;
    end
    wb_pipe_ready = 1'b1;
    run_vec(mk(1'b0, 1'b0, 3'd0, 32'h0000_BBBB, 32'h0, 32'h0, 5'd4, 1'b1, 0, 0,
               32'h0000_BBBB, 4'b0000, 32'h0), 21);
    idle(2);

    // Reset while waiting for a load response, then a late response.
    mem_pipe_valid = 1'b1; mem_pipe_mem_read = 1'b1; mem_pipe_mem_funct3 = F3_LW;
    mem_pipe_alu_result = 32'h0000_0400; mem_pipe_rd_write = 1'b1; mem_pipe_rd_addr = 5'd14;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    chk("rr_req_valid", 32'(dmem_req_valid), 32'd1);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    @(negedge clk);
    chk("rr_resp_wait", 32'(mem_pipe_ready), 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1; clear_inputs();
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    chk("rr_wb_valid", 32'(wb_pipe_valid), 32'd0);
    chk("rr_wb_rd_data", wb_pipe_rd_data, 32'h0);
    chk("rr_req_valid0", 32'(dmem_req_valid), 32'd0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rr_late_rsp", 32'(wb_pipe_valid), 32'd0);
      @(posedge clk); #1;
    end
    // The stage must be back in IDLE: passthrough and a load both flow normally.
    run_vec(mk(1'b0, 1'b0, 3'd0, 32'h0000_0777, 32'h0, 32'h0, 5'd15, 1'b1, 0, 0,
               32'h0000_0777, 4'b0000, 32'h0), 22);
    run_vec(mk(1'b1, 1'b0, F3_LHU, 32'h0000_0502, 32'h0, 32'h9ABC_0000, 5'd16, 1'b1, 0, 0,
               32'h0000_9ABC, 4'b0000, 32'h0), 23);
    idle(2);

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned LW: no request, flush pulse, misalign flag, rd_write dropped.
    mem_pipe_valid = 1'b1; mem_pipe_mem_read = 1'b1; mem_pipe_mem_funct3 = F3_LW;
    mem_pipe_alu_result = 32'h0000_0005; mem_pipe_rd_write = 1'b1; mem_pipe_rd_addr = 5'd17;
    mem_pipe_pc = 32'h2000; mem_pipe_instruction = 32'h0000_2003; dmem_req_ready = 1'b1;
    @(negedge clk);
    chk("trap_no_req", 32'(dmem_req_valid), 32'd0);
    chk("trap_ready", 32'(mem_pipe_ready), 32'd1);
    chk("trap_flush", 32'(mem_pipe_flush), 32'd1);
    mon_e.pc = 32'h2000; mon_e.instr = 32'h0000_2003; mon_e.rd_data = 32'h0000_0005;
    mon_e.rd_write = 1'b0; mon_e.rd_addr = 5'd17;
    sb_q.push_back(mon_e);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("trap_flush_end", 32'(mem_pipe_flush), 32'd0);
    chk("trap_misalign", 32'(wb_pipe_misalign), 32'd1);
    idle(2);
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
